path_sequencer: RTL



---
 rtl/path_sequencer.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/path_sequencer.sv
// path_sequencer: captures a planned node list, bursts it into the
// path mapper, then paces node_changed pulses off debounced node flags.
module path_sequencer #(
  parameter int MAX_NODES  = 16,
  parameter int NODE_W     = 5,
  parameter int SETTLE_CYC = 4,
  parameter int MIN_GAP    = 3125
) (
  input  logic              clk_3125KHz,
  input  logic              reset,
  input  logic              CPU_start,
  input  logic              abort,
  input  logic              node_valid,
  input  logic [NODE_W-1:0] node_in,
  input  logic              plan_done,
  input  logic              node_flag,
  output logic              path_input,
  output logic [NODE_W-1:0] path_planned,
  output logic              node_changed,
  output logic              busy,
  output logic              arrived,
  output logic              plan_err,
  output logic [NODE_W-1:0] nodes_left
);

  localparam int CW = $clog2(MAX_NODES + 1);
  localparam int AW = $clog2(MAX_NODES);
  localparam int GW = $clog2(MIN_GAP + 1);
  localparam int SW = $clog2(SETTLE_CYC + 1);

  localparam logic [CW-1:0] MAXC = CW'(MAX_NODES);
  localparam logic [GW-1:0] GAPC = GW'(MIN_GAP);
  localparam logic [SW-1:0] SETC = SW'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    LOAD,
    SETTLE,
    RUN,
    DONE
  } state_t;

  state_t            state_q;
  logic [NODE_W-1:0] mem_q [MAX_NODES];
  logic [CW-1:0]     count_q;
  logic [CW-1:0]     idx_q;
  logic [SW-1:0]     settle_q;
  logic [GW-1:0]     gap_q;
  logic              ovf_q;
  logic              flag_q;
  logic              flag_d_q;
  logic              start_q;
  logic              path_input_q;
  logic [NODE_W-1:0] path_planned_q;
  logic              node_changed_q;
  logic              busy_q;
  logic              arrived_q;
  logic              plan_err_q;
  logic [NODE_W-1:0] nodes_left_q;

  logic              start_rise;
  logic              flag_rise;
  logic              cap_wr;
  logic              cap_drop;
  logic [CW-1:0]     cap_cnt;
  logic [NODE_W-1:0] nl_dec;

  assign path_input   = path_input_q;
  assign path_planned = path_planned_q;
  assign node_changed = node_changed_q;
  assign busy         = busy_q;
  assign arrived      = arrived_q;
  assign plan_err     = plan_err_q;
  assign nodes_left   = nodes_left_q;

  // Edge detects and capture bookkeeping shared by the FSM.
  always_comb begin
    start_rise = CPU_start & ~start_q;
    flag_rise  = flag_q & ~flag_d_q;
    cap_wr     = node_valid && (count_q < MAXC);
    cap_drop   = node_valid && !(count_q < MAXC);
    cap_cnt    = count_q + CW'(cap_wr);
    nl_dec     = nodes_left_q - 1'b1;
  end

  // Sync the line-follower flag and keep history for edge detection.
  always_ff @(posedge clk_3125KHz) begin
    if (reset) begin
      flag_q   <= 1'b0;
      flag_d_q <= 1'b0;
      start_q  <= 1'b0;
    end else begin
      flag_q   <= node_flag;
      flag_d_q <= flag_q;
      start_q  <= CPU_start;
    end
  end

  // Node buffer; contents survive abort and reset.
  always_ff @(posedge clk_3125KHz) begin
    if (!reset && !abort && state_q == CAPTURE && cap_wr)
      mem_q[count_q[AW-1:0]] <= node_in;
  end

  // Main sequencer with registered outputs.
  always_ff @(posedge clk_3125KHz) begin
    if (reset) begin
      state_q        <= IDLE;
      count_q        <= '0;
      idx_q          <= '0;
      settle_q       <= '0;
      gap_q          <= '0;
      ovf_q          <= 1'b0;
      path_input_q   <= 1'b0;
      path_planned_q <= '0;
      node_changed_q <= 1'b0;
      busy_q         <= 1'b0;
      arrived_q      <= 1'b0;
      plan_err_q     <= 1'b0;
      nodes_left_q   <= '0;
    end else begin
      node_changed_q <= 1'b0;
      if (gap_q != '0) gap_q <= gap_q - 1'b1;
      if (abort) begin
        state_q      <= IDLE;
        path_input_q <= 1'b0;
        count_q      <= '0;
        busy_q       <= 1'b0;
        arrived_q    <= 1'b0;
        nodes_left_q <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (start_rise) begin
              state_q    <= CAPTURE;
              count_q    <= '0;
              plan_err_q <= 1'b0;
              ovf_q      <= 1'b0;
              busy_q     <= 1'b1;
            end
          end
          CAPTURE: begin
            if (cap_wr) count_q <= cap_cnt;
            if (cap_drop) begin
              plan_err_q <= 1'b1;
              ovf_q      <= 1'b1;
            end
            if (plan_done) begin
              if (cap_cnt >= CW'(2) && !ovf_q && !cap_drop) begin
                state_q        <= LOAD;
                path_input_q   <= 1'b1;
                path_planned_q <= mem_q[0];
                idx_q          <= CW'(1);
                nodes_left_q   <= NODE_W'(cap_cnt - 1'b1);
              end else begin
                state_q    <= IDLE;
                plan_err_q <= 1'b1;
                busy_q     <= 1'b0;
              end
            end
          end
          LOAD: begin
            if (idx_q == count_q) begin
              state_q      <= SETTLE;
              path_input_q <= 1'b0;
              settle_q     <= '0;
            end else begin
              path_planned_q <= mem_q[idx_q[AW-1:0]];
              idx_q          <= idx_q + 1'b1;
            end
          end
          SETTLE: begin
            if (settle_q == SETC) begin
              state_q        <= RUN;
              node_changed_q <= 1'b1;
              gap_q          <= GAPC;
            end else begin
              settle_q <= settle_q + 1'b1;
            end
          end
          RUN: begin
            if (flag_rise && gap_q == '0) begin
              gap_q        <= GAPC;
              nodes_left_q <= nl_dec;
              if (nl_dec == '0) begin
                state_q   <= DONE;
                busy_q    <= 1'b0;
                arrived_q <= 1'b1;
              end else begin
                node_changed_q <= 1'b1;
              end
            end
          end
          DONE: begin
            if (!CPU_start) begin
              state_q   <= IDLE;
              arrived_q <= 1'b0;
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
